mult_datapath: RTL and testbench
================================

# mult_datapath

Datapath for the repeated-addition multiplier, driven by the multiplier control FSM. Per-cycle strobes from the FSM register operands A and B, accumulate A into R1 once per loop cycle while the R2 iteration counter advances, and return the loop-continue status R2_LT_B. A one-entry result buffer holds the product F with a valid/ready handshake toward the consumer.

## Interface
- WIDTH, 3, operand width; product width is 2*WIDTH
- SYS_CLOCK  in  1  system clock, rising edge
- DP_ARESET  in  1  asynchronous, active-high reset
- A, B  in  WIDTH  raw operands, sampled when LOAD_A_REG / LOAD_B_REG are high
- LOAD_A_REG, LOAD_B_REG  in  1  load A_REG / B_REG
- LOAD_R1_REG  in  1  load accumulator R1 from ALU output
- ALU_CONT  in  1  1: ALU output = 0; 0: ALU output = MUX_IN1 + A_REG
- MUX_IN1_CONT  in  1  0: MUX_IN1 = R1; 1: MUX_IN1 = 0
- SCLR, INC  in  1  synchronous clear / increment of counter R2
- LOAD_F_REG  in  1  capture R1 into the result buffer
- R2_LT_B  out  1  combinational: (R2 + 1) < B_REG
- F  out  2*WIDTH  buffered product
- F_VALID  out  1  F holds an unconsumed result
- F_READY  in  1  consumer accepts F when F_VALID && F_READY
- OVERRUN  out  1  sticky: an unconsumed result was overwritten

## Operation
- Reset: A_REG, B_REG, R1, R2, F = 0; F_VALID = 0; OVERRUN = 0.
- ALU sum is computed at 2*WIDTH bits with A_REG zero-extended; wraps modulo 2^(2*WIDTH) (no wrap possible for legal FSM sequences; max 7*7 = 49 < 64).
- R2 is WIDTH bits. SCLR has priority over INC; INC alone wraps modulo 2^WIDTH.
- R2_LT_B compares at WIDTH+1 bits: (R2 + 1) < B_REG. Post-increment comparison makes the loop run exactly B_REG add cycles.
- Result buffer: LOAD_F_REG writes F <= R1 and sets F_VALID. Handshake F_VALID && F_READY clears F_VALID unless LOAD_F_REG is high in the same cycle.
- LOAD_F_REG while F_VALID = 1 and F_READY = 0: F is overwritten, F_VALID stays 1, OVERRUN set.
- LOAD_F_REG and accepted handshake in the same cycle: old F consumed, new F loaded, F_VALID stays 1, no overrun.
- OVERRUN clears only on reset.
- Strobes are honoured whenever asserted; the datapath does not check FSM state.

## Timing
- All registers update on the rising SYS_CLOCK edge; reset acts immediately and asynchronously.
- GO cycle T0 (FSM idle): A_REG, B_REG loaded, R1 = 0, R2 = 0 after edge.
- Loop cycles T1..TB: each edge performs R1 += A_REG and R2 += 1; R2_LT_B falls during TB.
- T(B+1): LOAD_F_REG; F and F_VALID visible from T(B+2). From GO sample to F_VALID: B+2 cycles.
- A = 0 or B = 0: FSM skips the loop; F = 0 valid 2 cycles after GO.
- Reset mid-loop: all state returns to reset values; a partial R1 never reaches F.

## Configuration
- MULT_DP_OVERRUN_EN defined: OVERRUN detection and sticky flag as above.
- Not defined: OVERRUN tied to 0, no flag register; overwrite behaviour of F and F_VALID unchanged.

## Structure
- Package mult_pkg: WIDTH default, operand_t (WIDTH bits), product_t (2*WIDTH bits), shared with the control FSM.
- Sub-module mult_result_buf: F register, F_VALID, handshake, and OVERRUN logic. Parameterised by product width.
- Operand registers, ALU, input mux, R2 counter, and comparator stay in the top level.

## Test plan
- Full sequence A=5, B=3, F_READY=1 -> exactly 3 loop cycles, R2_LT_B falls during the 3rd; F=15, F_VALID 5 cycles after GO.
- A=7, B=7 -> F=49, no wrap; A=0, B=6 and A=4, B=0 -> F=0 valid 2 cycles after GO.
- F_READY=0, two back-to-back products 2*3 then 3*3 -> F=9, F_VALID=1, OVERRUN=1 (0 with macro undefined).
- LOAD_F_REG coincident with accepted handshake -> F updated, F_VALID stays 1, OVERRUN stays 0.
- SCLR and INC together with R2=2 -> R2=0; INC at R2=7 -> R2=0.
- DP_ARESET asserted mid-loop (A=6, B=5, after 2 adds) -> all outputs 0 immediately; fresh 2*2 afterwards -> F=4.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the repeated-addition multiplier (datapath and control FSM).
package mult_pkg;

    localparam int DEF_WIDTH  = 3;
    localparam int DEF_PWIDTH = 2 * DEF_WIDTH;

    typedef logic [DEF_WIDTH-1:0]  operand_t;
    typedef logic [DEF_PWIDTH-1:0] product_t;

    typedef enum logic [1:0] {
        ALU_SRC_SUM  = 2'd0,
        ALU_SRC_ZERO = 2'd1
    } alu_src_e;

    function automatic product_t zext_operand(input operand_t op);
        return {{DEF_WIDTH{1'b0}}, op};
    endfunction

endpackage

// File: rtl/mult_result_buf.sv
// One-entry product buffer with valid/ready handshake.
// Optional sticky overwrite detection when MULT_DP_OVERRUN_EN is defined.
module mult_result_buf
    import mult_pkg::*;
#(
    parameter int PW = DEF_PWIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [PW-1:0] d,
    input  logic          ready,
    output logic [PW-1:0] f,
    output logic          f_valid,
    output logic          overrun
);

    logic [PW-1:0] f_r;
    logic          valid_r;

    // Product register and valid flag; a new load wins over a same-cycle consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_r     <= {PW{1'b0}};
            valid_r <= 1'b0;
        end else if (load) begin
            f_r     <= d;
            valid_r <= 1'b1;
        end else if (valid_r && ready) begin
            f_r     <= f_r;
            valid_r <= 1'b0;
        end else begin
            f_r     <= f_r;
            valid_r <= valid_r;
        end
    end

`ifdef MULT_DP_OVERRUN_EN
    logic overrun_r;

    // Sticky flag: a held result was replaced before the consumer took it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (load && valid_r && !ready) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign overrun = overrun_r;
`else
    assign overrun = 1'b0;
`endif

    assign f       = f_r;
    assign f_valid = valid_r;

endmodule

// File: rtl/mult_datapath.sv
// Repeated-addition multiplier datapath: operand regs, accumulator, loop counter, result buffer.
// Build option: MULT_DP_OVERRUN_EN enables the sticky OVERRUN flag in the result buffer.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 SYS_CLOCK,
    input  logic                 DP_ARESET,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 LOAD_A_REG,
    input  logic                 LOAD_B_REG,
    input  logic                 LOAD_R1_REG,
    input  logic                 ALU_CONT,
    input  logic                 MUX_IN1_CONT,
    input  logic                 SCLR,
    input  logic                 INC,
    input  logic                 LOAD_F_REG,
    output logic                 R2_LT_B,
    output logic [2*WIDTH-1:0]   F,
    output logic                 F_VALID,
    input  logic                 F_READY,
    output logic                 OVERRUN
);

    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] a_reg_r;
    logic [WIDTH-1:0] b_reg_r;
    logic [PW-1:0]    r1_r;
    logic [WIDTH-1:0] r2_r;
    logic [PW-1:0]    mux_in1_s;
    logic [PW-1:0]    alu_out_s;
    logic [WIDTH:0]   r2_next_s;

    // Operand capture, independent strobes per operand.
    always_ff @(posedge SYS_CLOCK or posedge DP_ARESET) begin
        if (DP_ARESET) begin
            a_reg_r <= {WIDTH{1'b0}};
            b_reg_r <= {WIDTH{1'b0}};
        end else begin
            a_reg_r <= LOAD_A_REG ? A : a_reg_r;
            b_reg_r <= LOAD_B_REG ? B : b_reg_r;
        end
    end

    // Input mux and ALU; A_REG is zero-extended so the sum never truncates for legal operands.
    always_comb begin
        mux_in1_s = {PW{1'b0}};
        alu_out_s = {PW{1'b0}};
        if (MUX_IN1_CONT) begin
            mux_in1_s = {PW{1'b0}};
        end else begin
            mux_in1_s = r1_r;
        end
        if (ALU_CONT) begin
            alu_out_s = {PW{1'b0}};
        end else begin
            alu_out_s = mux_in1_s + {{WIDTH{1'b0}}, a_reg_r};
        end
    end

    // Accumulator R1.
    always_ff @(posedge SYS_CLOCK or posedge DP_ARESET) begin
        if (DP_ARESET) begin
            r1_r <= {PW{1'b0}};
        end else if (LOAD_R1_REG) begin
            r1_r <= alu_out_s;
        end else begin
            r1_r <= r1_r;
        end
    end

    // Iteration counter R2; clear dominates increment.
    always_ff @(posedge SYS_CLOCK or posedge DP_ARESET) begin
        if (DP_ARESET) begin
            r2_r <= {WIDTH{1'b0}};
        end else if (SCLR) begin
            r2_r <= {WIDTH{1'b0}};
        end else if (INC) begin
            r2_r <= r2_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r2_r <= r2_r;
        end
    end

    // Post-increment compare at WIDTH+1 bits so the loop runs exactly B_REG times.
    assign r2_next_s = {1'b0, r2_r} + {{WIDTH{1'b0}}, 1'b1};
    assign R2_LT_B   = (r2_next_s < {1'b0, b_reg_r});

    mult_result_buf #(
        .PW (PW)
    ) u_result_buf (
        .clk     (SYS_CLOCK),
        .rst     (DP_ARESET),
        .load    (LOAD_F_REG),
        .d       (r1_r),
        .ready   (F_READY),
        .f       (F),
        .f_valid (F_VALID),
        .overrun (OVERRUN)
    );

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath; acts as the control FSM and compares against a*b arithmetic.
module tb_mult_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] a_in, b_in;
    logic       load_a, load_b, load_r1, alu_cont, mux_cont, sclr, inc, load_f, f_ready;
    logic       r2_lt_b, f_valid, overrun;
    logic [5:0] f_out;

    int checks = 0;
    int errors = 0;

`ifdef MULT_DP_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    mult_datapath #(.WIDTH(3)) dut (
        .SYS_CLOCK    (clk),
        .DP_ARESET    (rst),
        .A            (a_in),
        .B            (b_in),
        .LOAD_A_REG   (load_a),
        .LOAD_B_REG   (load_b),
        .LOAD_R1_REG  (load_r1),
        .ALU_CONT     (alu_cont),
        .MUX_IN1_CONT (mux_cont),
        .SCLR         (sclr),
        .INC          (inc),
        .LOAD_F_REG   (load_f),
        .R2_LT_B      (r2_lt_b),
        .F            (f_out),
        .F_VALID      (f_valid),
        .F_READY      (f_ready),
        .OVERRUN      (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        load_a = 1'b0; load_b = 1'b0; load_r1 = 1'b0; alu_cont = 1'b0;
        mux_cont = 1'b0; sclr = 1'b0; inc = 1'b0; load_f = 1'b0;
    endtask

    task automatic apply_reset();
        clear_strobes();
        f_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic drive_go(input int a, input int b);
        clear_strobes();
        a_in = 3'(a); b_in = 3'(b);
        load_a = 1'b1; load_b = 1'b1; load_r1 = 1'b1; alu_cont = 1'b1; sclr = 1'b1;
    endtask

    task automatic drive_loop();
        clear_strobes();
        load_r1 = 1'b1; inc = 1'b1;
    endtask

    // Plays the FSM for one product; reports R2_LT_B seen in each loop cycle and GO-to-valid latency.
    task automatic run_product(input int a, input int b, input bit rdy_loop, input bit rdy_load,
                               output int lat, output logic [15:0] lt_seen);
        int edges = 0;
        lat = 0;
        lt_seen = 16'h0000;
        f_ready = rdy_loop;
        drive_go(a, b);
        step(); edges++;
        if (f_valid && lat == 0) lat = edges;
        if (a != 0 && b != 0) begin
            for (int k = 1; k <= b; k++) begin
                drive_loop();
                lt_seen[k-1] = r2_lt_b;
                step(); edges++;
                if (f_valid && lat == 0) lat = edges;
            end
        end
        clear_strobes();
        load_f = 1'b1;
        f_ready = rdy_load;
        step(); edges++;
        if (f_valid && lat == 0) lat = edges;
        clear_strobes();
    endtask

    function automatic logic [15:0] exp_lt(input int a, input int b);
        if (a == 0 || b == 0) return 16'h0000;
        return 16'((1 << (b - 1)) - 1);
    endfunction

    function automatic int exp_lat(input int a, input int b);
        return (a == 0 || b == 0) ? 2 : b + 2;
    endfunction

    task automatic test_reset();
        clear_strobes();
        a_in = 3'd0; b_in = 3'd0; f_ready = 1'b0;
        rst = 1'b1;
        #3;
        checks++;
        if ({f_out, f_valid, overrun, r2_lt_b} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got F=%0d V=%b O=%b LT=%b want all 0", f_out, f_valid, overrun, r2_lt_b);
        end
        step(); step();
        rst = 1'b0;
        #1;
    endtask

    task automatic check_product(input string name, input int a, input int b);
        int lat;
        logic [15:0] lt;
        run_product(a, b, 1'b1, 1'b1, lat, lt);
        checks++;
        if (f_out !== 6'(a * b) || f_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_f: got F=%0d V=%b want F=%0d V=1", name, f_out, f_valid, a * b);
        end
        checks++;
        if (lat != exp_lat(a, b)) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat(a, b));
        end
        checks++;
        if (lt !== exp_lt(a, b)) begin
            errors++;
            $display("FAIL %s_lt_pattern: got %b want %b", name, lt, exp_lt(a, b));
        end
    endtask

    task automatic test_basic();
        check_product("a5b3", 5, 3);
    endtask

    task automatic test_corners();
        check_product("a7b7", 7, 7);
        check_product("a0b6", 0, 6);
        check_product("a4b0", 4, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            check_product("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_r2_counter();
        int lat;
        logic [15:0] lt;
        run_product(3, 2, 1'b1, 1'b1, lat, lt);
        drive_go(3, 2);
        step();
        clear_strobes();
        inc = 1'b1;
        step(); step();
        checks++;
        if (r2_lt_b !== 1'b0) begin
            errors++;
            $display("FAIL r2_at_2: got LT=%b want 0", r2_lt_b);
        end
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        checks++;
        if (r2_lt_b !== 1'b1) begin
            errors++;
            $display("FAIL sclr_priority: got LT=%b want 1", r2_lt_b);
        end
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (r2_lt_b !== 1'b0) begin
            errors++;
            $display("FAIL r2_at_7: got LT=%b want 0", r2_lt_b);
        end
        step();
        clear_strobes();
        checks++;
        if (r2_lt_b !== 1'b1) begin
            errors++;
            $display("FAIL r2_wrap: got LT=%b want 1", r2_lt_b);
        end
    endtask

    task automatic test_coincident();
        int lat;
        logic [15:0] lt;
        apply_reset();
        run_product(2, 2, 1'b0, 1'b0, lat, lt);
        run_product(3, 1, 1'b0, 1'b1, lat, lt);
        f_ready = 1'b0;
        checks++;
        if (f_out !== 6'd3 || f_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL coincident: got F=%0d V=%b O=%b want F=3 V=1 O=0", f_out, f_valid, overrun);
        end
    endtask

    task automatic test_overrun();
        int lat;
        logic [15:0] lt;
        apply_reset();
        run_product(2, 3, 1'b0, 1'b0, lat, lt);
        checks++;
        if (f_out !== 6'd6 || f_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_first: got F=%0d V=%b O=%b want F=6 V=1 O=0", f_out, f_valid, overrun);
        end
        run_product(3, 3, 1'b0, 1'b0, lat, lt);
        checks++;
        if (f_out !== 6'd9 || f_valid !== 1'b1 || overrun !== OVR_EN) begin
            errors++;
            $display("FAIL overrun_second: got F=%0d V=%b O=%b want F=9 V=1 O=%b", f_out, f_valid, overrun, OVR_EN);
        end
        step(); step();
        checks++;
        if (overrun !== OVR_EN || f_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got O=%b V=%b want O=%b V=1", overrun, f_valid, OVR_EN);
        end
    endtask

    task automatic test_reset_mid_loop();
        int lat;
        logic [15:0] lt;
        apply_reset();
        run_product(2, 2, 1'b0, 1'b0, lat, lt);
        drive_go(6, 5);
        step();
        drive_loop();
        step(); step();
        rst = 1'b1;
        #2;
        checks++;
        if ({f_out, f_valid, overrun, r2_lt_b} !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid_loop: got F=%0d V=%b O=%b LT=%b want all 0", f_out, f_valid, overrun, r2_lt_b);
        end
        clear_strobes();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (f_out !== 6'd0 || f_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got F=%0d V=%b want F=0 V=0", f_out, f_valid);
        end
        check_product("after_reset", 2, 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_r2_counter();
        test_coincident();
        test_overrun();
        test_reset_mid_loop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
